// File: rtl/board_swap_engine.sv
`default_nettype none
// ============================================================================
//  Module      : board_swap_engine
//  Description : Match-3 board owner. Holds the board, cursor and selection,
//                accepts one command at a time over valid/ready, and runs a
//                swap / run-length match check / commit-or-revert sequence.
//  Revision    : 1.0 - initial release
// ============================================================================
module board_swap_engine #(
  parameter int COLS          = 8,
  parameter int ROWS          = 8,
  parameter int CW            = 3,
  parameter int XW            = 4,
  parameter int YW            = 4,
  parameter int WRAP          = 0,
  parameter int ALLOW_NOMATCH = 0
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic                     board_load,
  input  logic [ROWS*COLS*CW-1:0]  board_in,
  input  logic                     op_valid,
  input  logic [3:0]               op,
  output logic                     op_ready,
  output logic [ROWS*COLS*CW-1:0]  board_out,
  output logic [XW-1:0]            cursor_x,
  output logic [YW-1:0]            cursor_y,
  output logic                     selected,
  output logic                     done,
  output logic                     moved,
  output logic                     match_found
);

  localparam int BW = ROWS*COLS*CW;
  localparam int IW = $clog2(BW);

  localparam logic [2:0] S_IDLE  = 3'd0;
  localparam logic [2:0] S_SWAP  = 3'd1;
  localparam logic [2:0] S_CHK_A = 3'd2;
  localparam logic [2:0] S_CHK_B = 3'd3;
  localparam logic [2:0] S_FIN   = 3'd4;

  localparam logic [3:0] OP_SEL    = 4'd1;
  localparam logic [3:0] OP_UP     = 4'd2;
  localparam logic [3:0] OP_DOWN   = 4'd3;
  localparam logic [3:0] OP_LEFT   = 4'd4;
  localparam logic [3:0] OP_RIGHT  = 4'd5;
  localparam logic [3:0] OP_CANCEL = 4'd6;

  logic [2:0]    state;
  logic [BW-1:0] board;
  logic [XW-1:0] bx;        // swap partner column, latched at accept
  logic [YW-1:0] by;        // swap partner row, latched at accept
  logic          match_a;
  logic          match_b;

  int            nbr_x;
  int            nbr_y;
  logic          nbr_in_bounds;
  logic          is_dir;
  logic [XW-1:0] mv_x;
  logic [YW-1:0] mv_y;
  logic [IW-1:0] idx_a;
  logic [IW-1:0] idx_b;
  logic [BW-1:0] swapped;
  logic [XW-1:0] chk_x;
  logic [YW-1:0] chk_y;
  logic          chk_match;

  // Fetch one cell; callers guarantee (x,y) lies on the board.
  function automatic logic [CW-1:0] get_cell(input logic [BW-1:0] b,
                                             input int x, input int y);
    return b[IW'((y*COLS + x)*CW) +: CW];
  endfunction

  // A non-empty cell matches when its horizontal or vertical run reaches 3.
  // Only two neighbours per direction matter for a run of three.
  function automatic logic cell_match(input logic [BW-1:0] b,
                                      input int x, input int y);
    logic [CW-1:0] c;
    int   h;
    int   v;
    logic run_l, run_r, run_u, run_d;
    c = get_cell(b, x, y);
    h = 1;
    v = 1;
    run_l = 1'b1;
    run_r = 1'b1;
    run_u = 1'b1;
    run_d = 1'b1;
    for (int k = 1; k <= 2; k++) begin
      if (run_l && (x - k >= 0) && (get_cell(b, x - k, y) == c)) h = h + 1;
      else run_l = 1'b0;
      if (run_r && (x + k < COLS) && (get_cell(b, x + k, y) == c)) h = h + 1;
      else run_r = 1'b0;
      if (run_u && (y - k >= 0) && (get_cell(b, x, y - k) == c)) v = v + 1;
      else run_u = 1'b0;
      if (run_d && (y + k < ROWS) && (get_cell(b, x, y + k) == c)) v = v + 1;
      else run_d = 1'b0;
    end
    return (c != '0) && ((h >= 3) || (v >= 3));
  endfunction

  assign op_ready  = (state == S_IDLE) && !board_load && !rst;
  assign board_out = board;

  // Swap target and bounds check for the direction command on the bus.
  always_comb begin
    nbr_x = int'(cursor_x);
    nbr_y = int'(cursor_y);
    is_dir = 1'b1;
    case (op)
      OP_UP:    nbr_y = int'(cursor_y) - 1;
      OP_DOWN:  nbr_y = int'(cursor_y) + 1;
      OP_LEFT:  nbr_x = int'(cursor_x) - 1;
      OP_RIGHT: nbr_x = int'(cursor_x) + 1;
      default:  is_dir = 1'b0;
    endcase
    nbr_in_bounds = (nbr_x >= 0) && (nbr_x < COLS) && (nbr_y >= 0) && (nbr_y < ROWS);
  end

  // Cursor destination for an unselected move, clamping or wrapping at edges.
  always_comb begin
    mv_x = cursor_x;
    mv_y = cursor_y;
    case (op)
      OP_UP: begin
        if (cursor_y == '0) mv_y = (WRAP != 0) ? YW'(ROWS - 1) : cursor_y;
        else                mv_y = cursor_y - YW'(1);
      end
      OP_DOWN: begin
        if (cursor_y == YW'(ROWS - 1)) mv_y = (WRAP != 0) ? '0 : cursor_y;
        else                           mv_y = cursor_y + YW'(1);
      end
      OP_LEFT: begin
        if (cursor_x == '0) mv_x = (WRAP != 0) ? XW'(COLS - 1) : cursor_x;
        else                mv_x = cursor_x - XW'(1);
      end
      OP_RIGHT: begin
        if (cursor_x == XW'(COLS - 1)) mv_x = (WRAP != 0) ? '0 : cursor_x;
        else                           mv_x = cursor_x + XW'(1);
      end
      default: ;
    endcase
  end

  // Board with cells A (cursor) and B (latched partner) exchanged; applying
  // it twice restores the original, so it serves both swap and revert.
  always_comb begin
    idx_a   = IW'((int'(cursor_y)*COLS + int'(cursor_x))*CW);
    idx_b   = IW'((int'(by)*COLS + int'(bx))*CW);
    swapped = board;
    swapped[idx_a +: CW] = board[idx_b +: CW];
    swapped[idx_b +: CW] = board[idx_a +: CW];
  end

  // One match evaluator shared between the CHK_A and CHK_B cycles.
  always_comb begin
    chk_x     = (state == S_CHK_A) ? cursor_x : bx;
    chk_y     = (state == S_CHK_A) ? cursor_y : by;
    chk_match = cell_match(board, int'(chk_x), int'(chk_y));
  end

  // Command FSM: single-edge commands in IDLE, four-edge swap sequence otherwise.
  always_ff @(posedge clk) begin
    if (rst) begin
      state       <= S_IDLE;
      board       <= '0;
      cursor_x    <= '0;
      cursor_y    <= '0;
      selected    <= 1'b0;
      bx          <= '0;
      by          <= '0;
      match_a     <= 1'b0;
      match_b     <= 1'b0;
      done        <= 1'b0;
      moved       <= 1'b0;
      match_found <= 1'b0;
    end else begin
      done        <= 1'b0;
      moved       <= 1'b0;
      match_found <= 1'b0;
      case (state)
        S_IDLE: begin
          if (board_load) begin
            board    <= board_in;
            selected <= 1'b0;
          end else if (op_valid) begin
            done <= 1'b1;
            if (op == OP_SEL) begin
              selected <= !selected;
            end else if (op == OP_CANCEL) begin
              selected <= 1'b0;
            end else if (is_dir) begin
              if (!selected) begin
                cursor_x <= mv_x;
                cursor_y <= mv_y;
              end else if (nbr_in_bounds) begin
                // Swap accepted: completion is reported from FIN instead.
                done  <= 1'b0;
                bx    <= XW'(nbr_x);
                by    <= YW'(nbr_y);
                state <= S_SWAP;
              end
            end
          end
        end
        S_SWAP: begin
          board <= swapped;
          state <= S_CHK_A;
        end
        S_CHK_A: begin
          match_a <= chk_match;
          state   <= S_CHK_B;
        end
        S_CHK_B: begin
          match_b <= chk_match;
          state   <= S_FIN;
        end
        S_FIN: begin
          if (match_a || match_b || (ALLOW_NOMATCH != 0)) begin
            cursor_x <= bx;
            cursor_y <= by;
            moved    <= 1'b1;
          end else begin
            board <= swapped;
          end
          match_found <= match_a | match_b;
          done        <= 1'b1;
          selected    <= 1'b0;
          state       <= S_IDLE;
        end
        default: state <= S_IDLE;
      endcase
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_board_swap_engine.sv
`default_nettype none
// ============================================================================
//  Module      : tb_board_swap_engine
//  Description : Directed self-checking bench. Instance "a" uses WRAP=0,
//                ALLOW_NOMATCH=0; instance "b" uses WRAP=1, ALLOW_NOMATCH=1.
//                Both share every input.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_board_swap_engine;

  localparam int BW = 192;

  logic          clk = 1'b0;
  logic          rst = 1'b1;
  logic          board_load = 1'b0;
  logic [BW-1:0] board_in = '0;
  logic          op_valid = 1'b0;
  logic [3:0]    op = 4'd0;

  logic          ready_a, sel_a, done_a, moved_a, mf_a;
  logic [BW-1:0] bout_a;
  logic [3:0]    cx_a, cy_a;
  logic          ready_b, sel_b, done_b, moved_b, mf_b;
  logic [BW-1:0] bout_b;
  logic [3:0]    cx_b, cy_b;

  int n_cmp = 0;
  int n_bad = 0;

  board_swap_engine #(.COLS(8), .ROWS(8), .CW(3), .XW(4), .YW(4),
                      .WRAP(0), .ALLOW_NOMATCH(0)) dut_a (
    .clk(clk), .rst(rst), .board_load(board_load), .board_in(board_in),
    .op_valid(op_valid), .op(op), .op_ready(ready_a), .board_out(bout_a),
    .cursor_x(cx_a), .cursor_y(cy_a), .selected(sel_a), .done(done_a),
    .moved(moved_a), .match_found(mf_a));

  board_swap_engine #(.COLS(8), .ROWS(8), .CW(3), .XW(4), .YW(4),
                      .WRAP(1), .ALLOW_NOMATCH(1)) dut_b (
    .clk(clk), .rst(rst), .board_load(board_load), .board_in(board_in),
    .op_valid(op_valid), .op(op), .op_ready(ready_b), .board_out(bout_b),
    .cursor_x(cx_b), .cursor_y(cy_b), .selected(sel_b), .done(done_b),
    .moved(moved_b), .match_found(mf_b));

  always #5 clk = ~clk;

  function automatic logic [BW-1:0] put(input logic [BW-1:0] b, input int x,
                                        input int y, input int c);
    logic [BW-1:0] r;
    r = b;
    r[(y*8 + x)*3 +: 3] = 3'(c);
    return r;
  endfunction

  function automatic int cell_of(input logic [BW-1:0] b, input int x, input int y);
    return int'(b[(y*8 + x)*3 +: 3]);
  endfunction

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic do_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    tick();
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic issue(input logic [3:0] o);
    @(negedge clk);
    op_valid = 1'b1;
    op = o;
    tick();
    op_valid = 1'b0;
    op = 4'd0;
  endtask

  task automatic load(input logic [BW-1:0] b);
    @(negedge clk);
    board_load = 1'b1;
    board_in = b;
    tick();
    board_load = 1'b0;
  endtask

  // Row 0 = 1,1,2,3,4,5,6,7 and (2,1)=1: swapping (2,0) down makes 1,1,1.
  function automatic logic [BW-1:0] match_board();
    logic [BW-1:0] b;
    int r0[8] = '{1, 1, 2, 3, 4, 5, 6, 7};
    b = '0;
    for (int x = 0; x < 8; x++) b = put(b, x, 0, r0[x]);
    b = put(b, 2, 1, 1);
    return b;
  endfunction

  task automatic test_reset();
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL reset_ready: got %b want 0", ready_a); end
    tick();
    n_cmp++; if (bout_a !== '0) begin n_bad++; $display("FAIL reset_board: got %h want 0", bout_a); end
    n_cmp++; if ({cx_a, cy_a} !== 8'h00) begin n_bad++; $display("FAIL reset_cursor: got %h want 00", {cx_a, cy_a}); end
    n_cmp++; if ({sel_a, done_a, moved_a, mf_a} !== 4'b0) begin n_bad++; $display("FAIL reset_flags: got %b want 0000", {sel_a, done_a, moved_a, mf_a}); end
    @(negedge clk);
    rst = 1'b0;
    #1;
    n_cmp++; if (ready_a !== 1'b1) begin n_bad++; $display("FAIL reset_release_ready: got %b want 1", ready_a); end
  endtask

  task automatic test_cursor_moves();
    int dones_a, dones_b, moves;
    dones_a = 0; dones_b = 0; moves = 0;
    do_reset();
    for (int i = 0; i < 9; i++) begin
      issue(4'd5);
      if (done_a) dones_a++;
      if (done_b) dones_b++;
      if (moved_a || moved_b) moves++;
      if (i == 7) begin
        n_cmp++; if (cx_b !== 4'd0) begin n_bad++; $display("FAIL wrap_after_8: got %0d want 0", cx_b); end
      end
    end
    n_cmp++; if (cx_a !== 4'd7) begin n_bad++; $display("FAIL clamp_x: got %0d want 7", cx_a); end
    n_cmp++; if (cx_b !== 4'd1) begin n_bad++; $display("FAIL wrap_x: got %0d want 1", cx_b); end
    n_cmp++; if (dones_a !== 9 || dones_b !== 9) begin n_bad++; $display("FAIL move_dones: got %0d/%0d want 9/9", dones_a, dones_b); end
    n_cmp++; if (moves !== 0) begin n_bad++; $display("FAIL move_moved: got %0d want 0", moves); end
    // Up at row 0: a clamps, b wraps to row 7.
    issue(4'd2);
    n_cmp++; if (cy_a !== 4'd0 || cy_b !== 4'd7) begin n_bad++; $display("FAIL edge_up: got %0d/%0d want 0/7", cy_a, cy_b); end
  endtask

  task automatic test_out_of_bounds();
    logic [BW-1:0] b;
    int r0[8] = '{1, 1, 2, 1, 3, 4, 5, 6};
    b = '0;
    for (int x = 0; x < 8; x++) b = put(b, x, 0, r0[x]);
    do_reset();
    load(b);
    issue(4'd5);
    issue(4'd5);
    issue(4'd1);
    n_cmp++; if (sel_a !== 1'b1 || done_a !== 1'b1) begin n_bad++; $display("FAIL select: got sel=%b done=%b want 1 1", sel_a, done_a); end
    issue(4'd2);
    n_cmp++; if ({done_a, moved_a, mf_a, sel_a} !== 4'b1001) begin n_bad++; $display("FAIL oob_flags: got %b want 1001", {done_a, moved_a, mf_a, sel_a}); end
    n_cmp++; if (bout_a !== b) begin n_bad++; $display("FAIL oob_board: got %h want %h", bout_a, b); end
    n_cmp++; if (ready_a !== 1'b1 || cx_a !== 4'd2 || cy_a !== 4'd0) begin n_bad++; $display("FAIL oob_state: got rdy=%b x=%0d y=%0d want 1 2 0", ready_a, cx_a, cy_a); end
    issue(4'd6);
    n_cmp++; if (sel_a !== 1'b0) begin n_bad++; $display("FAIL cancel: got %b want 0", sel_a); end
  endtask

  task automatic test_swap_match();
    do_reset();
    load(match_board());
    issue(4'd5);
    issue(4'd5);
    issue(4'd1);
    issue(4'd3);
    n_cmp++; if (ready_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL swap_e0: got rdy=%b done=%b want 0 0", ready_a, done_a); end
    tick();
    n_cmp++; if (cell_of(bout_a, 2, 0) !== 1 || cell_of(bout_a, 2, 1) !== 2) begin n_bad++; $display("FAIL swap_e1_board: got %0d,%0d want 1,2", cell_of(bout_a, 2, 0), cell_of(bout_a, 2, 1)); end
    tick();
    tick();
    n_cmp++; if (ready_a !== 1'b0 || done_a !== 1'b0) begin n_bad++; $display("FAIL swap_e3_busy: got rdy=%b done=%b want 0 0", ready_a, done_a); end
    tick();
    n_cmp++; if ({ready_a, done_a, moved_a, mf_a} !== 4'b1111) begin n_bad++; $display("FAIL swap_fin_flags: got %b want 1111", {ready_a, done_a, moved_a, mf_a}); end
    n_cmp++; if (cell_of(bout_a, 2, 0) !== 1 || cell_of(bout_a, 2, 1) !== 2) begin n_bad++; $display("FAIL swap_fin_board: got %0d,%0d want 1,2", cell_of(bout_a, 2, 0), cell_of(bout_a, 2, 1)); end
    n_cmp++; if (cx_a !== 4'd2 || cy_a !== 4'd1 || sel_a !== 1'b0) begin n_bad++; $display("FAIL swap_fin_cursor: got x=%0d y=%0d sel=%b want 2 1 0", cx_a, cy_a, sel_a); end
    tick();
    n_cmp++; if (done_a !== 1'b0) begin n_bad++; $display("FAIL done_pulse_width: got %b want 0", done_a); end
  endtask

  task automatic test_swap_nomatch();
    logic [BW-1:0] b;
    int r0[8] = '{1, 2, 3, 4, 5, 6, 7, 1};
    int r1[8] = '{2, 3, 4, 5, 6, 7, 1, 2};
    b = '0;
    for (int x = 0; x < 8; x++) begin
      b = put(b, x, 0, r0[x]);
      b = put(b, x, 1, r1[x]);
    end
    do_reset();
    load(b);
    issue(4'd5);
    issue(4'd5);
    issue(4'd1);
    issue(4'd3);
    tick();
    n_cmp++; if (cell_of(bout_a, 2, 0) !== 4 || cell_of(bout_a, 2, 1) !== 3) begin n_bad++; $display("FAIL nm_e1_board: got %0d,%0d want 4,3", cell_of(bout_a, 2, 0), cell_of(bout_a, 2, 1)); end
    tick();
    tick();
    tick();
    n_cmp++; if ({done_a, moved_a, mf_a} !== 3'b100) begin n_bad++; $display("FAIL nm_flags_a: got %b want 100", {done_a, moved_a, mf_a}); end
    n_cmp++; if (bout_a !== b) begin n_bad++; $display("FAIL nm_revert: got %h want %h", bout_a, b); end
    n_cmp++; if (cx_a !== 4'd2 || cy_a !== 4'd0 || sel_a !== 1'b0) begin n_bad++; $display("FAIL nm_cursor_a: got x=%0d y=%0d sel=%b want 2 0 0", cx_a, cy_a, sel_a); end
    n_cmp++; if ({done_b, moved_b, mf_b} !== 3'b110) begin n_bad++; $display("FAIL nm_flags_b: got %b want 110", {done_b, moved_b, mf_b}); end
    n_cmp++; if (cell_of(bout_b, 2, 0) !== 4 || cell_of(bout_b, 2, 1) !== 3 || cy_b !== 4'd1) begin n_bad++; $display("FAIL nm_keep_b: got %0d,%0d y=%0d want 4,3 1", cell_of(bout_b, 2, 0), cell_of(bout_b, 2, 1), cy_b); end
  endtask

  task automatic test_reset_mid_swap();
    do_reset();
    load(match_board());
    issue(4'd5);
    issue(4'd5);
    issue(4'd1);
    issue(4'd3);
    tick();
    tick();
    // Now in CHK_B: reset lands on the next edge.
    @(negedge clk);
    rst = 1'b1;
    tick();
    n_cmp++; if (bout_a !== '0 || cx_a !== 4'd0 || cy_a !== 4'd0 || sel_a !== 1'b0) begin n_bad++; $display("FAIL midrst_state: got x=%0d y=%0d sel=%b board_nonzero=%b want 0 0 0 0", cx_a, cy_a, sel_a, |bout_a); end
    n_cmp++; if (done_a !== 1'b0 || ready_a !== 1'b0) begin n_bad++; $display("FAIL midrst_flags: got done=%b rdy=%b want 0 0", done_a, ready_a); end
    @(negedge clk);
    rst = 1'b0;
    tick();
    n_cmp++; if (ready_a !== 1'b1 || done_a !== 1'b0) begin n_bad++; $display("FAIL midrst_after: got rdy=%b done=%b want 1 0", ready_a, done_a); end
  endtask

  task automatic test_load_and_op();
    logic [BW-1:0] b;
    b = match_board();
    do_reset();
    @(negedge clk);
    board_load = 1'b1;
    board_in = b;
    op_valid = 1'b1;
    op = 4'd1;
    #1;
    n_cmp++; if (ready_a !== 1'b0) begin n_bad++; $display("FAIL load_ready: got %b want 0", ready_a); end
    tick();
    board_load = 1'b0;
    n_cmp++; if (bout_a !== b || done_a !== 1'b0 || sel_a !== 1'b0) begin n_bad++; $display("FAIL load_edge: got done=%b sel=%b board_ok=%b want 0 0 1", done_a, sel_a, bout_a === b); end
    tick();
    op_valid = 1'b0;
    op = 4'd0;
    n_cmp++; if (done_a !== 1'b1 || sel_a !== 1'b1) begin n_bad++; $display("FAIL held_op: got done=%b sel=%b want 1 1", done_a, sel_a); end
  endtask

  initial begin
    #200000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

  initial begin
    test_reset();
    test_cursor_moves();
    test_out_of_bounds();
    test_swap_match();
    test_swap_nomatch();
    test_reset_mid_swap();
    test_load_and_op();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
